handshake_unpacker: RTL and testbench
=====================================

Name: handshake_unpacker

Overview:
- Consumer-side reader for a one-entry handshake buffer. It drains the buffer's data_out / data_out_valid / pop side.
- Each upstream entry is a bundle of LANES lanes with a per-lane valid mask. The block emits the valid lanes one per cycle, lowest index first, into a downstream push/full interface.
- Used between fetch-bundle buffering and per-instruction decode/issue stages.
- Upstream data is not copied: it is read in place while in_data_valid is high.

Parameters:
- LANES, 4, number of lanes per bundle (>=1)
- LANE_WIDTH, 32, bits per lane
- IDX_WIDTH, (LANES > 1) ? $clog2(LANES) : 1, lane index width (derived, not to be overridden)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard in-progress bundle state
- in_data  input  LANES*LANE_WIDTH  bundle; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH]
- in_valid_mask  input  LANES  per-lane valid bits of the bundle
- in_data_valid  input  1  upstream holds a bundle (stable until popped)
- in_pop  output  1  bundle fully consumed this cycle
- out_data  output  LANE_WIDTH  selected lane payload
- out_lane_index  output  IDX_WIDTH  index of selected lane
- out_last  output  1  selected lane is the final pending lane of the bundle
- out_push  output  1  beat offered downstream
- out_full  input  1  downstream cannot accept this cycle

Behaviour:
- State: cons_mask[LANES], lanes of the current bundle already emitted. Reset value 0. No other state.
- pending = in_data_valid ? (in_valid_mask & ~cons_mask) : 0.
- sel = lowest set index of pending (0 if none).
- out_data = lane sel of in_data. out_lane_index = sel.
- out_last = pending has exactly one bit set.
- out_push = !rst & !flush & (pending != 0).
- Beat accepted when out_push & !out_full.
- in_pop = !rst & !flush & in_data_valid & ((pending == 0) | (accepted & out_last)).
- Sequential update, priority order:
  - rst | flush -> cons_mask <= 0
  - else if in_pop -> cons_mask <= 0
  - else if accepted -> cons_mask[sel] <= 1
  - else hold
- All outputs are combinational. With rst high, out_push = 0 and in_pop = 0; out_data / out_lane_index / out_last are don't-care.
- out_full must not depend combinationally on out_push. in_pop may depend combinationally on out_full.
- Throughput: a bundle with k valid lanes completes in k accepted cycles, with in_pop asserted in the cycle of the k-th acceptance.
- Zero-mask bundle: popped in one cycle with no beat emitted.
- Back-to-back bundles: the next bundle's first beat is offered the cycle after in_pop, with no bubble beyond that cycle.
- Backpressure: while out_full is high, out_push stays high with out_data, out_lane_index and out_last stable; cons_mask does not change.
- in_data_valid low mid-bundle (protocol violation): no outputs; cons_mask is held.
- flush or rst mid-bundle: cons_mask cleared. If the upstream bundle is still present afterwards, it restarts from its lowest valid lane. The upstream buffer is expected to be flushed in the same cycle.
- LANES == 1: each bundle yields at most one beat, and out_last = 1 whenever out_push = 1.

Decomposition:
- No package typedefs needed. LANE_WIDTH / LANES defaults come from the existing config header constants for fetch width.
- One sub-module: lowest_set_index (parameter WIDTH; input vec; outputs idx and any).
- out_last is computed as pending & (pending - 1) == 0 inline.

Test Plan:
- mask 4'b1011, lanes A0..A3, out_full = 0 -> out_push cycles 0,1,2 with indices 0,1,3 and data A0,A1,A3; out_last only in cycle 2; in_pop only in cycle 2.
- mask 4'b0000, in_data_valid = 1 -> in_pop = 1 in cycle 0, out_push = 0 throughout.
- mask 4'b1111, out_full = 1 in cycles 1-2 -> lane 1 is held stable in cycles 1-3 and accepted in cycle 3; lanes 2,3 go out in cycles 4,5; in_pop in cycle 5.
- Bundle B1 mask 4'b0011 then B2 mask 4'b1000, upstream refilled immediately -> beats B1.0, B1.1, B2.3 in three consecutive cycles (plus upstream reload cycle); in_pop after B1.1 and after B2.3.
- mask 4'b0111, flush asserted in cycle 1 after lane 0 accepted -> no push and no pop in cycle 1; cons_mask = 0 in cycle 2. A new bundle with mask 4'b0110 then emits lane 1 first.
- rst asserted for 1 cycle mid-bundle -> identical behaviour to flush; after release, the first beat is the lowest valid lane of the present bundle.

Source files
------------

// File: rtl/handshake_unpacker_pkg.sv
// Shared fetch-width configuration for the bundle unpacker and its helpers.
package handshake_unpacker_pkg;

  // Number of instruction lanes carried by one fetch bundle.
  localparam int FETCH_LANES = 4;

  // Width of a single fetch lane in bits.
  localparam int FETCH_LANE_WIDTH = 32;

endpackage : handshake_unpacker_pkg

// File: rtl/handshake_unpacker_lowest_set_index.sv
// Priority encoder: reports the lowest set bit of vec and whether any bit is set.
module lowest_set_index #(
  parameter int WIDTH = 4,
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDXW'(i);
        any = 1'b1;
      end
    end
  end

endmodule : lowest_set_index

// File: rtl/handshake_unpacker.sv
// Drains a one-entry bundle buffer and emits its valid lanes one per cycle,
// lowest index first. The bundle is read in place; only a consumed-lane mask
// is kept locally.
module handshake_unpacker
  import handshake_unpacker_pkg::*;
#(
  parameter int LANES = FETCH_LANES,
  parameter int LANE_WIDTH = FETCH_LANE_WIDTH,
  localparam int IDX_WIDTH = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [LANES*LANE_WIDTH-1:0] in_data,
  input  logic [LANES-1:0]            in_valid_mask,
  input  logic                        in_data_valid,
  output logic                        in_pop,
  output logic [LANE_WIDTH-1:0]       out_data,
  output logic [IDX_WIDTH-1:0]        out_lane_index,
  output logic                        out_last,
  output logic                        out_push,
  input  logic                        out_full
);

  logic [LANES-1:0]      cons_mask;
  logic [LANES-1:0]      pending;
  logic [IDX_WIDTH-1:0]  sel;
  logic                  pending_any;
  logic                  accepted;
  logic [LANE_WIDTH-1:0] lanes [LANES];

  // Slice the flat bundle into addressable lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lanes[g] = in_data[g*LANE_WIDTH +: LANE_WIDTH];
  end

  // Lanes still to be emitted from the bundle currently presented upstream.
  assign pending = in_data_valid ? (in_valid_mask & ~cons_mask) : '0;

  lowest_set_index #(
    .WIDTH (LANES)
  ) u_sel (
    .vec (pending),
    .idx (sel),
    .any (pending_any)
  );

  assign out_data       = lanes[sel];
  assign out_lane_index = sel;
  assign out_last       = pending_any && ((pending & (pending - LANES'(1))) == '0);
  assign out_push       = !rst && !flush && pending_any;
  assign accepted       = out_push && !out_full;

  // An empty bundle is released immediately; otherwise on its final accepted lane.
  assign in_pop = !rst && !flush && in_data_valid && (!pending_any || (accepted && out_last));

  // Track consumed lanes; cleared on reset, flush, or when the bundle is released.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cons_mask <= '0;
    end else if (in_pop) begin
      cons_mask <= '0;
    end else if (accepted) begin
      cons_mask[sel] <= 1'b1;
    end
  end

endmodule : handshake_unpacker

// File: tb/tb_handshake_unpacker.sv
// Scoreboard bench for handshake_unpacker: the driver queues the beats and
// bundle releases it expects, and a monitor checks what the DUT presents.
module tb_handshake_unpacker;

  localparam int LANES = 4;
  localparam int LW    = 32;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [LANES*LW-1:0] in_data;
  logic [LANES-1:0] in_valid_mask;
  logic             in_data_valid;
  logic             in_pop;
  logic [LW-1:0]    out_data;
  logic [1:0]       out_lane_index;
  logic             out_last;
  logic             out_push;
  logic             out_full;

  int total = 0;
  int bad   = 0;

  beat_t exp_beats[$];
  int    exp_pops[$];
  int    exp_beat_total = 0;
  int    seen_beats = 0;

  logic          held = 1'b0;
  beat_t         held_beat;

  handshake_unpacker #(
    .LANES      (LANES),
    .LANE_WIDTH (LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid_mask  (in_valid_mask),
    .in_data_valid  (in_data_valid),
    .in_pop         (in_pop),
    .out_data       (out_data),
    .out_lane_index (out_lane_index),
    .out_last       (out_last),
    .out_push       (out_push),
    .out_full       (out_full)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queue the beats produced by the lanes in emit, plus the release token.
  task automatic expectLanes(input logic [LANES*LW-1:0] data, input logic [LANES-1:0] emit);
    int hi;
    hi = -1;
    for (int i = 0; i < LANES; i++) if (emit[i]) hi = i;
    for (int i = 0; i < LANES; i++) begin
      if (emit[i]) begin
        beat_t b;
        b.data = data[i*LW +: LW];
        b.idx  = 2'(i);
        b.last = (i == hi);
        exp_beats.push_back(b);
        exp_beat_total++;
      end
    end
    exp_pops.push_back(exp_beat_total);
  endtask

  // Present a bundle until the DUT releases it, driving out_full from full_pat.
  task automatic applyStimulus(input logic [LANES*LW-1:0] data, input logic [LANES-1:0] mask,
                               input logic [LANES-1:0] emit, input logic [15:0] full_pat,
                               input int exp_pop_cycle, input bit refill);
    int  cyc;
    bit  popped;
    expectLanes(data, emit);
    in_data       = data;
    in_valid_mask = mask;
    in_data_valid = 1'b1;
    popped        = 1'b0;
    cyc           = 0;
    while (!popped && cyc < 16) begin
      out_full = full_pat[cyc];
      @(negedge clk);
      if (in_pop) popped = 1'b1;
      else cyc++;
      @(posedge clk);
      #1;
    end
    out_full = 1'b0;
    if (!popped) begin
      total++;
      bad++;
      $display("[TB] FAIL pop_timeout: got no pop expected pop in cycle %0d", exp_pop_cycle);
    end else begin
      checkOutput("pop_cycle", 64'(cyc), 64'(exp_pop_cycle));
    end
    if (!refill) in_data_valid = 1'b0;
  endtask

  // Monitor: checks quiet outputs, backpressure stability, beats and releases.
  always @(negedge clk) begin
    if (rst || flush) begin
      checkOutput("quiet_rst_flush", {62'd0, out_push, in_pop}, 64'd0);
    end else if (!in_data_valid) begin
      checkOutput("quiet_no_valid", {62'd0, out_push, in_pop}, 64'd0);
    end
    if (held) begin
      checkOutput("hold_push", {63'd0, out_push}, 64'd1);
      checkOutput("hold_beat", 64'({out_data, out_lane_index, out_last}), 64'(held_beat));
    end
    held = out_push && out_full;
    held_beat = {out_data, out_lane_index, out_last};
    if (out_push && !out_full) begin
      if (exp_beats.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_beat: got idx %0d data %0h expected none", out_lane_index, out_data);
      end else begin
        beat_t e;
        e = exp_beats.pop_front();
        checkOutput("beat", 64'({out_data, out_lane_index, out_last}), 64'(e));
      end
      seen_beats++;
    end
    if (in_pop) begin
      if (exp_pops.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pop: got pop after %0d beats expected none", seen_beats);
      end else begin
        checkOutput("pop_after_beats", 64'(seen_beats), 64'(exp_pops.pop_front()));
      end
    end
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [LANES*LW-1:0] a, b1, b2, c, d, e, g, h;
    a  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    b1 = {32'hB1B1_0013, 32'hB1B1_0012, 32'hB1B1_0011, 32'hB1B1_0010};
    b2 = {32'hB2B2_0023, 32'hB2B2_0022, 32'hB2B2_0021, 32'hB2B2_0020};
    c  = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
    d  = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    e  = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
    g  = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
    h  = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

    rst = 1'b1; flush = 1'b0; out_full = 1'b0;
    in_data = a; in_valid_mask = 4'b1111; in_data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_data_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] sparse mask 1011");
    applyStimulus(a, 4'b1011, 4'b1011, 16'h0000, 2, 1'b0);
    @(posedge clk); #1;

    $display("[TB] empty mask");
    applyStimulus(a, 4'b0000, 4'b0000, 16'h0000, 0, 1'b0);
    @(posedge clk); #1;

    $display("[TB] full mask with backpressure");
    applyStimulus(c, 4'b1111, 4'b1111, 16'h0006, 5, 1'b0);
    @(posedge clk); #1;

    $display("[TB] back-to-back bundles");
    applyStimulus(b1, 4'b0011, 4'b0011, 16'h0000, 1, 1'b1);
    applyStimulus(b2, 4'b1000, 4'b1000, 16'h0000, 0, 1'b0);
    @(posedge clk); #1;

    $display("[TB] flush mid-bundle");
    exp_beats.push_back('{data: d[LW-1:0], idx: 2'd0, last: 1'b0});
    exp_beat_total++;
    in_data = d; in_valid_mask = 4'b0111; in_data_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    applyStimulus(e, 4'b0110, 4'b0110, 16'h0000, 1, 1'b0);
    @(posedge clk); #1;

    $display("[TB] reset mid-bundle");
    exp_beats.push_back('{data: g[LW-1:0], idx: 2'd0, last: 1'b0});
    exp_beat_total++;
    in_data = g; in_valid_mask = 4'b0111; in_data_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(g, 4'b0111, 4'b0111, 16'h0000, 2, 1'b0);
    @(posedge clk); #1;

    $display("[TB] upstream valid drop mid-bundle");
    exp_beats.push_back('{data: h[LW-1:0], idx: 2'd0, last: 1'b0});
    exp_beat_total++;
    in_data = h; in_valid_mask = 4'b1111; in_data_valid = 1'b1;
    @(posedge clk); #1;
    in_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(h, 4'b1111, 4'b1110, 16'h0000, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("beats_left", 64'(exp_beats.size()), 64'd0);
    checkOutput("pops_left", 64'(exp_pops.size()), 64'd0);
    checkOutput("beats_seen", 64'(seen_beats), 64'(exp_beat_total));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_handshake_unpacker
